// File: rtl/uart_timing_pkg.sv
// Shared defaults and helpers for the UART timing block.
package uart_timing_pkg;

    localparam int unsigned DEF_CLK_FREQ_HZ = 50_000_000;
    localparam int unsigned DEF_BAUD_RATE   = 9600;
    localparam logic [31:0] DEF_TICK_TIME   = 32'd5000;
    localparam logic [3:0]  DEF_PULSE_WIDTH = 4'd2;

    localparam int CNT_W = 32;

    // Rounded clock/baud ratio so the bit period error stays under half a cycle.
    function automatic logic [CNT_W-1:0] calc_baud_div(input int unsigned clk_hz,
                                                       input int unsigned baud);
        return CNT_W'((clk_hz + baud / 2) / baud);
    endfunction

endpackage

// File: rtl/tick_generator.sv
// Free-running divider producing a one-cycle registered strobe every tick_time
// cycles. tick_time = 0 keeps the strobe low; tick_time = 1 holds it high.
module tick_generator
    import uart_timing_pkg::*;
#(
    parameter logic [CNT_W-1:0] tick_time = DEF_TICK_TIME
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam logic            ENABLED = (tick_time != '0);
    localparam logic [CNT_W-1:0] LAST   = ENABLED ? tick_time - CNT_W'(1) : '0;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // Count 0..tick_time-1; the wrap cycle is flagged and appears on tick one edge later.
    always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        tick_d = 1'b0;
        if (!ENABLED) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    // Counter and strobe registers; reset restarts the phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_tx_timing.sv
// UART transmit timing: baud strobe, general-purpose tick strobe and a
// retriggerable fixed-width pulse fired on every edge of generate_pulse.
module uart_tx_timing
    import uart_timing_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
    parameter int unsigned BAUD_RATE   = DEF_BAUD_RATE,
    parameter logic [31:0] TICK_TIME   = DEF_TICK_TIME,
    parameter logic [3:0]  PULSE_WIDTH = DEF_PULSE_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic generate_pulse,
    output logic baud_tick,
    output logic tick,
    output logic pulse
);

    localparam logic [CNT_W-1:0] BAUD_DIV = calc_baud_div(CLK_FREQ_HZ, BAUD_RATE);

    generate
        if (BAUD_DIV < 1) begin : g_bad_baud_div
            $error("uart_tx_timing: baud divisor must be at least 1");
        end
    endgenerate

    tick_generator #(.tick_time(BAUD_DIV)) u_baud_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (baud_tick)
    );

    tick_generator #(.tick_time(TICK_TIME)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    logic       gp_q;
    logic       req;
    logic       pulse_q, pulse_d;
    logic [3:0] width_q, width_d;

    // Any level change versus last cycle is a request; a request (re)starts the
    // width count, otherwise count up and drop once PULSE_WIDTH cycles are done.
    always_comb begin
        req     = (generate_pulse != gp_q);
        pulse_d = pulse_q;
        width_d = width_q;
        if (PULSE_WIDTH == 4'd0) begin
            pulse_d = 1'b0;
            width_d = 4'd0;
        end else if (req) begin
            pulse_d = 1'b1;
            width_d = 4'd1;
        end else if (pulse_q) begin
            if (width_q >= PULSE_WIDTH) begin
                pulse_d = 1'b0;
                width_d = 4'd0;
            end else begin
                width_d = width_q + 4'd1;
            end
        end
    end

    // Input history and pulse state; gp_q clears so a high level at release counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            gp_q    <= 1'b0;
            pulse_q <= 1'b0;
            width_q <= 4'd0;
        end else begin
            gp_q    <= generate_pulse;
            pulse_q <= pulse_d;
            width_q <= width_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: tb/tb_uart_tx_timing.sv
// Bench for uart_tx_timing: small-parameter instances checked per cycle against
// an arithmetic model, plus a long run of the default configuration.
module tb_uart_tx_timing;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, gp = 1'b0;
    logic rst_d = 1'b1, gp_d = 1'b0;
    logic bt_m, tk_m, pl_m, bt_1, tk_1, pl_1, bt_0, tk_0, pl_0, bt_d, tk_d, pl_d;

    uart_tx_timing #(.CLK_FREQ_HZ(100), .BAUD_RATE(10), .TICK_TIME(5), .PULSE_WIDTH(2)) dut_m (
        .clk(clk), .rst(rst), .generate_pulse(gp), .baud_tick(bt_m), .tick(tk_m), .pulse(pl_m));
    uart_tx_timing #(.CLK_FREQ_HZ(100), .BAUD_RATE(10), .TICK_TIME(1), .PULSE_WIDTH(0)) dut_1 (
        .clk(clk), .rst(rst), .generate_pulse(gp), .baud_tick(bt_1), .tick(tk_1), .pulse(pl_1));
    uart_tx_timing #(.CLK_FREQ_HZ(100), .BAUD_RATE(10), .TICK_TIME(0), .PULSE_WIDTH(2)) dut_0 (
        .clk(clk), .rst(rst), .generate_pulse(gp), .baud_tick(bt_0), .tick(tk_0), .pulse(pl_0));
    uart_tx_timing dut_d (
        .clk(clk), .rst(rst_d), .generate_pulse(gp_d), .baud_tick(bt_d), .tick(tk_d), .pulse(pl_d));

    logic [8:0] obs;
    assign obs = {bt_m, tk_m, pl_m, bt_1, tk_1, pl_1, bt_0, tk_0, pl_0};

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: cycle index since release, cycle of latest pulse start,
    // and the input level seen last cycle.
    int         m_cyc  = 0;
    int         m_last = -1;
    logic       m_prev = 1'b0;
    logic [8:0] e_vec  = '0;

    function automatic logic every(input int c, input int p);
        if (p <= 0 || c <= 0) return 1'b0;
        return (c % p) == 0;
    endfunction

    function automatic logic in_pulse(input int c, input int last, input int pw);
        if (pw <= 0 || last < 0) return 1'b0;
        return (c - last) < pw;
    endfunction

    // Advance one clock edge, update expectations for the new cycle, then let
    // the caller drive this cycle's inputs.
    task automatic adv();
        @(posedge clk);
        if (rst) begin
            m_cyc  = 0;
            m_last = -1;
            m_prev = 1'b0;
            e_vec  = '0;
        end else begin
            m_cyc++;
            if (gp != m_prev) m_last = m_cyc;
            m_prev = gp;
            e_vec = {every(m_cyc, 10), every(m_cyc, 5), in_pulse(m_cyc, m_last, 2),
                     every(m_cyc, 10), every(m_cyc, 1), in_pulse(m_cyc, m_last, 0),
                     every(m_cyc, 10), every(m_cyc, 0), in_pulse(m_cyc, m_last, 2)};
        end
        #1;
    endtask

    task automatic do_reset(input logic g);
        for (int i = 0; i < 2; i++) begin
            adv();
            rst = 1'b1;
            gp  = g;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            adv();
            rst = 1'b1; gp = 1'b0; rst_d = 1'b1;
            @(negedge clk);
            n_checks++;
            if (obs !== 9'b0 || {bt_d, tk_d, pl_d} !== 3'b0) begin
                n_err++;
                $display("FAIL reset cyc=%0d got=%b/%b exp=0", i, obs, {bt_d, tk_d, pl_d});
            end
        end
    endtask

    task automatic test_ticks();
        int nt = 0, nb = 0;
        do_reset(1'b0);
        for (int i = 0; i < 36; i++) begin
            adv();
            rst = 1'b0; gp = 1'b0;
            @(negedge clk);
            nt += int'(tk_m);
            nb += int'(bt_m);
            n_checks++;
            if (obs !== e_vec) begin
                n_err++;
                $display("FAIL ticks cyc=%0d got=%b exp=%b", i, obs, e_vec);
            end
        end
        n_checks++;
        if (nt != 7 || nb != 3) begin
            n_err++;
            $display("FAIL tick_counts got tick=%0d baud=%0d exp tick=7 baud=3", nt, nb);
        end
    endtask

    task automatic test_pulse();
        logic [39:0] got = '0, exp_m = '0;
        exp_m[4] = 1'b1; exp_m[5] = 1'b1; exp_m[21] = 1'b1; exp_m[22] = 1'b1;
        do_reset(1'b0);
        for (int i = 0; i < 30; i++) begin
            adv();
            rst = 1'b0; gp = (i >= 3 && i < 20);
            @(negedge clk);
            got[i] = pl_m;
            n_checks++;
            if (obs !== e_vec) begin
                n_err++;
                $display("FAIL pulse cyc=%0d got=%b exp=%b", i, obs, e_vec);
            end
        end
        n_checks++;
        if (got !== exp_m) begin
            n_err++;
            $display("FAIL pulse_mask got=%h exp=%h", got, exp_m);
        end
    endtask

    task automatic test_restart();
        logic [39:0] got = '0, exp_m = '0;
        exp_m[4] = 1'b1; exp_m[5] = 1'b1; exp_m[6] = 1'b1;
        do_reset(1'b0);
        for (int i = 0; i < 12; i++) begin
            adv();
            rst = 1'b0; gp = (i == 3);
            @(negedge clk);
            got[i] = pl_m;
            n_checks++;
            if (obs !== e_vec) begin
                n_err++;
                $display("FAIL restart cyc=%0d got=%b exp=%b", i, obs, e_vec);
            end
        end
        n_checks++;
        if (got !== exp_m) begin
            n_err++;
            $display("FAIL restart_mask got=%h exp=%h", got, exp_m);
        end
    endtask

    task automatic test_reset_mid_pulse();
        do_reset(1'b0);
        for (int i = 0; i < 20; i++) begin
            adv();
            rst = (i == 4 || i == 5); gp = (i >= 3);
            @(negedge clk);
            n_checks++;
            if (obs !== e_vec) begin
                n_err++;
                $display("FAIL midreset cyc=%0d got=%b exp=%b", i, obs, e_vec);
            end
            if (i == 5 || i == 6) begin
                n_checks++;
                if ({bt_m, tk_m, pl_m} !== 3'b000) begin
                    n_err++;
                    $display("FAIL midreset_low cyc=%0d got=%b exp=000", i, {bt_m, tk_m, pl_m});
                end
            end
            if (i == 11) begin
                n_checks++;
                if (tk_m !== 1'b1) begin
                    n_err++;
                    $display("FAIL midreset_tick cyc=%0d got=%b exp=1", i, tk_m);
                end
            end
        end
    endtask

    task automatic test_release_high();
        logic [15:0] got = '0, exp_m = '0;
        exp_m[1] = 1'b1; exp_m[2] = 1'b1;
        do_reset(1'b1);
        for (int i = 0; i < 10; i++) begin
            adv();
            rst = 1'b0; gp = 1'b1;
            @(negedge clk);
            got[i] = pl_m;
            n_checks++;
            if (obs !== e_vec) begin
                n_err++;
                $display("FAIL relhigh cyc=%0d got=%b exp=%b", i, obs, e_vec);
            end
        end
        n_checks++;
        if (got !== exp_m) begin
            n_err++;
            $display("FAIL relhigh_mask got=%h exp=%h", got, exp_m);
        end
    endtask

    task automatic test_random();
        int toggles = 0;
        do_reset(1'b0);
        for (int i = 0; i < 400; i++) begin
            adv();
            rst = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 2) == 0) begin
                gp = ~gp;
                toggles++;
            end
            @(negedge clk);
            n_checks++;
            if (obs !== e_vec) begin
                n_err++;
                $display("FAIL random cyc=%0d got=%b exp=%b", i, obs, e_vec);
            end
        end
        $display("random: %0d toggles", toggles);
    endtask

    task automatic test_default_spacing();
        int last_b = 0, last_t = 0, nb = 0, nt = 0, np = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            rst_d = 1'b1;
        end
        for (int c = 0; c < 26100; c++) begin
            @(posedge clk); #1;
            rst_d = 1'b0;
            @(negedge clk);
            np += int'(pl_d);
            if (bt_d === 1'b1) begin
                n_checks++;
                if (c - last_b != 5208) begin
                    n_err++;
                    $display("FAIL baud_spacing at=%0d got=%0d exp=5208", c, c - last_b);
                end
                last_b = c;
                nb++;
            end
            if (tk_d === 1'b1) begin
                n_checks++;
                if (c - last_t != 5000) begin
                    n_err++;
                    $display("FAIL tick_spacing at=%0d got=%0d exp=5000", c, c - last_t);
                end
                last_t = c;
                nt++;
            end
        end
        n_checks++;
        if (nb != 5 || nt != 5 || np != 0) begin
            n_err++;
            $display("FAIL default_counts got baud=%0d tick=%0d pulse=%0d exp 5 5 0", nb, nt, np);
        end
    endtask

    initial begin
        test_reset();
        test_ticks();
        test_pulse();
        test_restart();
        test_reset_mid_pulse();
        test_release_high();
        test_random();
        test_default_spacing();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
